// File: rtl/bcd_sseg_scan_if.sv
// Bundle of the display driver's data inputs and display outputs.
// The master side drives digits, decimal points, load and blank_lz; the slave side drives the display.
interface bcd_sseg_scan_if #(
  parameter int N_DIGITS = 4
);
  // No valid/ready pair: load is a level sampled at every clk edge, and at that
  // same edge bcd_in/dp_in are captured. No back-pressure exists, because a new
  // snapshot can be taken at any edge. blank_lz is read every cycle and is not held.
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  blank_lz;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            sseg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output bcd_in, dp_in, load, blank_lz,
    input  an, sseg, dp, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz,
    output an, sseg, dp, frame_done
  );
endinterface

// File: rtl/bcd_sseg_scan.sv
// Time-multiplexed common-anode 7-segment driver for packed BCD digits.
// All outputs are registered one cycle behind the scan index and the snapshot.
module bcd_sseg_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic           clk,
  input logic           reset_n,
  bcd_sseg_scan_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] snap_bcd;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   an_q;
  logic [6:0]            sseg_q;
  logic                  dp_q;
  logic                  frame_done_q;

  logic                  tick;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [N_DIGITS-1:0]   lz;
  logic                  zero_run;
  logic [6:0]            seg_dec;
  logic [N_DIGITS-1:0]   an_next;

  assign tick    = (prescaler == PRE_LAST);
  assign an_next = ~(N_DIGITS'(1) << idx);

  // lz[i] is set when digit i and every digit above it are zero; digit 0 never qualifies.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (snap_bcd[4*i +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_digit = snap_bcd[4*i +: 4];
        cur_dp    = snap_dp[i];
        cur_lz    = lz[i];
      end
    end
  end

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  always_comb begin
    seg_dec = 7'b0111111;
    case (cur_digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler    <= '0;
      idx          <= '0;
      snap_bcd     <= '0;
      snap_dp      <= '0;
      an_q         <= '1;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (bus.load) begin
        snap_bcd <= bus.bcd_in;
        snap_dp  <= bus.dp_in;
      end
      frame_done_q <= tick && (idx == IDX_LAST);
      an_q         <= an_next;
      sseg_q       <= (bus.blank_lz && cur_lz) ? 7'h7F : seg_dec;
      dp_q         <= ~cur_dp;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_sseg_scan.sv
// Directed bench for bcd_sseg_scan (N_DIGITS=4, REFRESH_DIV=4): expected display states and
// their hold times are queued by the driver and checked by a monitor at every output change.
module tb_bcd_sseg_scan;
  localparam int N  = 4;
  localparam int RD = 4;

  logic clk;
  logic reset_n;
  int   n_total = 0;
  int   n_bad   = 0;
  int   e       = 0;

  // Entry: {hold_cycles[7:0], an[3:0], sseg[6:0], dp}; hold_cycles 0 = not checked.
  logic [19:0] exp_q[$];
  // Expected frame_done spacing in cycles; 0 = not checked.
  int          fd_q[$];

  bcd_sseg_scan_if #(.N_DIGITS(N)) bus ();

  bcd_sseg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [19:0] ent(input int len, input logic [3:0] a,
                                      input logic [6:0] s, input logic d);
    return {8'(len), a, s, d};
  endfunction

  // driver tasks
  task automatic next_cyc();
    @(negedge clk);
    #2;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) next_cyc();
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpo);
    exp_q.push_back(ent(4, 4'b1110, s0, dpo[0]));
    exp_q.push_back(ent(4, 4'b1101, s1, dpo[1]));
    exp_q.push_back(ent(4, 4'b1011, s2, dpo[2]));
    exp_q.push_back(ent(4, 4'b0111, s3, dpo[3]));
    fd_q.push_back(16);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},   32'(bus.an), 32'hF);
    check({tag, "_sseg"}, 32'(bus.sseg), 32'h7F);
    check({tag, "_dp"},   32'(bus.dp), 32'h1);
    check({tag, "_fd"},   32'(bus.frame_done), 32'h0);
  endtask

  // scoreboard monitor
  initial begin
    logic [11:0] cur_t;
    logic [11:0] t;
    logic [19:0] x;
    int          cur_len;
    int          cur_exp_len;
    int          fd_gap;
    int          fd_exp;
    bit          have_cur;
    bit          prev_fd;
    have_cur = 1'b0;
    prev_fd  = 1'b0;
    fd_gap   = 0;
    cur_len  = 0;
    cur_exp_len = 0;
    cur_t    = '0;
    forever begin
      @(negedge clk);
      t = {bus.an, bus.sseg, bus.dp};
      if (!have_cur || t !== cur_t) begin
        if (have_cur && cur_exp_len != 0) check("slot_len", 32'(cur_len), 32'(cur_exp_len));
        if (exp_q.size() == 0) begin
          check("unexpected_state", 32'(t), 32'hFFFFFFFF);
          cur_exp_len = 0;
        end else begin
          x = exp_q.pop_front();
          check("display", 32'(t), 32'(x[11:0]));
          cur_exp_len = int'(x[19:12]);
        end
        cur_t    = t;
        cur_len  = 1;
        have_cur = 1'b1;
      end else begin
        cur_len++;
      end
      fd_gap++;
      if (prev_fd) check("fd_width", 32'(bus.frame_done), 32'h0);
      if (bus.frame_done === 1'b1) begin
        check("fd_an", 32'(bus.an), 32'h7);
        if (fd_q.size() == 0) begin
          check("fd_unexpected", 32'h1, 32'h0);
        end else begin
          fd_exp = fd_q.pop_front();
          if (fd_exp != 0) check("fd_gap", 32'(fd_gap), 32'(fd_exp));
        end
        fd_gap = 0;
      end
      prev_fd = (bus.frame_done === 1'b1);
    end
  end

  // stimulus
  initial begin
    reset_n      = 1'b1;
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    exp_q.push_back(ent(0, 4'b1111, 7'h7F, 1'b1));
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("rst0");
    repeat (3) next_cyc();

    // 1234 loaded on the first edge after release; edge 1 still shows the zero snapshot
    reset_n    = 1'b1;
    bus.bcd_in = 16'h1234;
    bus.load   = 1'b1;
    e          = 0;
    exp_q.push_back(ent(1, 4'b1110, 7'h40, 1'b1));
    exp_q.push_back(ent(3, 4'b1110, 7'h19, 1'b1));
    exp_q.push_back(ent(4, 4'b1101, 7'h30, 1'b1));
    exp_q.push_back(ent(4, 4'b1011, 7'h24, 1'b1));
    exp_q.push_back(ent(4, 4'b0111, 7'h79, 1'b1));
    fd_q.push_back(0);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1111);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1111);
    next_cyc();
    bus.load = 1'b0;

    // 0070 with leading-zero blanking, then without
    run_to(47);
    bus.bcd_in = 16'h0070;
    bus.load   = 1'b1;
    push_frame(7'h40, 7'h78, 7'h7F, 7'h7F, 4'b1111);
    run_to(48);
    bus.load     = 1'b0;
    bus.blank_lz = 1'b1;
    run_to(64);
    bus.blank_lz = 1'b0;
    push_frame(7'h40, 7'h78, 7'h40, 7'h40, 4'b1111);

    // 00FA with dp on digit 2: dashes, then blanking keeps dp
    run_to(79);
    bus.bcd_in = 16'h00FA;
    bus.dp_in  = 4'b0100;
    bus.load   = 1'b1;
    push_frame(7'h3F, 7'h3F, 7'h40, 7'h40, 4'b1011);
    run_to(80);
    bus.load = 1'b0;
    run_to(96);
    bus.blank_lz = 1'b1;
    push_frame(7'h3F, 7'h3F, 7'h7F, 7'h7F, 4'b1011);

    // load coincides with the frame-ending tick
    run_to(111);
    bus.bcd_in = 16'h9999;
    bus.dp_in  = 4'b0000;
    bus.load   = 1'b1;
    push_frame(7'h10, 7'h10, 7'h10, 7'h10, 4'b1111);
    run_to(112);
    bus.load = 1'b0;

    // reset in the middle of the digit-0 slot, scan restarts on a zero snapshot
    exp_q.push_back(ent(2, 4'b1110, 7'h10, 1'b1));
    exp_q.push_back(ent(2, 4'b1111, 7'h7F, 1'b1));
    exp_q.push_back(ent(4, 4'b1110, 7'h40, 1'b1));
    exp_q.push_back(ent(4, 4'b1101, 7'h7F, 1'b1));
    exp_q.push_back(ent(4, 4'b1011, 7'h7F, 1'b1));
    exp_q.push_back(ent(4, 4'b0111, 7'h7F, 1'b1));
    exp_q.push_back(ent(0, 4'b1110, 7'h40, 1'b1));
    fd_q.push_back(0);
    run_to(130);
    reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    e       = 0;
    run_to(18);

    check("exp_q_left", 32'(exp_q.size()), 32'h0);
    check("fd_q_left",  32'(fd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
